// File: rtl/zba_pkg.sv
// Shared Zba encodings and request/response records for the address-generation unit.
package zba_pkg;

  localparam logic [2:0] F3_SH1ADD = 3'b010;
  localparam logic [2:0] F3_SH2ADD = 3'b100;
  localparam logic [2:0] F3_SH3ADD = 3'b110;
  localparam logic [2:0] F3_ADDUW  = 3'b000;
  localparam logic [2:0] F3_SLLIUW = 3'b001;

  // Records are sized for the widest configuration; narrower units use the low bits.
  localparam int ZBA_XLEN_MAX  = 64;
  localparam int ZBA_TAG_W_MAX = 8;

  typedef struct packed {
    logic [2:0]               funct3;
    logic                     uw;
    logic [5:0]               shamt;
    logic [ZBA_XLEN_MAX-1:0]  rs1;
    logic [ZBA_XLEN_MAX-1:0]  rs2;
    logic [ZBA_TAG_W_MAX-1:0] tag;
  } zba_req_t;

  typedef struct packed {
    logic [ZBA_XLEN_MAX-1:0]  result;
    logic [ZBA_TAG_W_MAX-1:0] tag;
    logic                     illegal;
  } zba_resp_t;

endpackage

// File: rtl/zba_pipe_stage.sv
// One elastic register slice: holds a word while downstream stalls, accepts when empty or draining.
module zba_pipe_stage
  import zba_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data
);

  logic             vld_p0;
  logic [WIDTH-1:0] data_p0;

  // Advance when empty or when the downstream side takes the current word.
  assign up_ready = !vld_p0 || dn_ready;
  assign dn_valid = vld_p0;
  assign dn_data  = data_p0;

  // Stage boundary: flush kills the valid bit only, data keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
    end else if (flush) begin
      vld_p0  <= 1'b0;
    end else if (up_ready) begin
      vld_p0 <= up_valid;
      if (up_valid) begin
        data_p0 <= up_data;
      end
    end
  end

endmodule

// File: rtl/zba_pipe_unit.sv
// Pipelined Zba address generation: SHnADD, ADD.UW, SHnADD.UW, SLLI.UW with tag passthrough.
module zba_pipe_unit
  import zba_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter int STAGES    = 2,
  parameter int TAG_W     = 5,
  parameter int ENABLE_UW = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_funct3,
  input  logic             in_uw,
  input  logic [5:0]       in_shamt,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  // Word variants only exist on RV64.
  localparam bit UW_OK = (ENABLE_UW != 0) && (XLEN == 64);
  localparam int DW    = XLEN + TAG_W + 1;

  function automatic zba_resp_t zba_compute(input zba_req_t r);
    zba_resp_t             o;
    logic [ZBA_XLEN_MAX-1:0] a;
    logic                  ill;
    o   = '0;
    a   = r.uw ? {32'h0, r.rs1[31:0]} : r.rs1;
    ill = r.uw && !UW_OK;
    case (r.funct3)
      F3_SH1ADD: o.result = r.rs2 + (a << 1);
      F3_SH2ADD: o.result = r.rs2 + (a << 2);
      F3_SH3ADD: o.result = r.rs2 + (a << 3);
      F3_ADDUW: begin
        ill      = ill || !r.uw;
        o.result = r.rs2 + a;
      end
      F3_SLLIUW: begin
        ill      = ill || !r.uw || ((XLEN == 32) && r.shamt[5]);
        o.result = a << r.shamt;
      end
      default: ill = 1'b1;
    endcase
    if (ill) begin
      o.result = '0;
    end
    o.tag     = r.tag;
    o.illegal = ill;
    return o;
  endfunction

  zba_req_t  req_p0;
  zba_resp_t resp_p0;

  logic [STAGES:0]         vld_p;
  logic [STAGES:0]         rdy_p;
  logic [STAGES:0][DW-1:0] dat_p;

  // Stage 0 input: decode and compute straight from the issue operands.
  always_comb begin
    req_p0        = '0;
    req_p0.funct3 = in_funct3;
    req_p0.uw     = in_uw;
    req_p0.shamt  = in_shamt;
    req_p0.rs1    = ZBA_XLEN_MAX'(in_rs1);
    req_p0.rs2    = ZBA_XLEN_MAX'(in_rs2);
    req_p0.tag    = ZBA_TAG_W_MAX'(in_tag);
    resp_p0       = zba_compute(req_p0);
  end

  assign vld_p[0]      = in_valid;
  assign dat_p[0]      = {resp_p0.illegal, resp_p0.tag[TAG_W-1:0], resp_p0.result[XLEN-1:0]};
  assign rdy_p[STAGES] = out_ready;
  assign in_ready      = rdy_p[0] && !rst && !flush;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    zba_pipe_stage #(.WIDTH(DW)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (vld_p[g]),
      .up_ready (rdy_p[g]),
      .up_data  (dat_p[g]),
      .dn_valid (vld_p[g+1]),
      .dn_ready (rdy_p[g+1]),
      .dn_data  (dat_p[g+1])
    );
  end

  // Output stage: last slice drives the writeback side.
  assign out_valid   = vld_p[STAGES];
  assign out_result  = dat_p[STAGES][XLEN-1:0];
  assign out_tag     = dat_p[STAGES][XLEN +: TAG_W];
  assign out_illegal = dat_p[STAGES][DW-1];

endmodule

// File: tb/tb_zba_pipe_unit.sv
// Directed bench for zba_pipe_unit: RV64 two-stage unit plus an RV32 single-stage unit.
module tb_zba_pipe_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic        in_valid, in_ready, in_uw, out_valid, out_ready, out_illegal;
  logic [2:0]  in_funct3;
  logic [5:0]  in_shamt;
  logic [63:0] in_rs1, in_rs2, out_result;
  logic [4:0]  in_tag, out_tag;

  logic        flush32, in_valid32, in_ready32, in_uw32, out_valid32, out_ready32, out_illegal32;
  logic [2:0]  in_funct3_32;
  logic [5:0]  in_shamt32;
  logic [31:0] in_rs1_32, in_rs2_32, out_result32;
  logic [4:0]  in_tag32, out_tag32;

  zba_pipe_unit #(.XLEN(64), .STAGES(2), .TAG_W(5), .ENABLE_UW(1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_funct3(in_funct3), .in_uw(in_uw), .in_shamt(in_shamt), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_illegal(out_illegal)
  );

  zba_pipe_unit #(.XLEN(32), .STAGES(1), .TAG_W(5), .ENABLE_UW(1)) dut32 (
    .clk(clk), .rst(rst), .flush(flush32), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_funct3(in_funct3_32), .in_uw(in_uw32), .in_shamt(in_shamt32), .in_rs1(in_rs1_32),
    .in_rs2(in_rs2_32), .in_tag(in_tag32), .out_valid(out_valid32), .out_ready(out_ready32),
    .out_result(out_result32), .out_tag(out_tag32), .out_illegal(out_illegal32)
  );

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", name, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] f3, input logic uw, input logic [5:0] sh,
                       input logic [63:0] rs1, input logic [63:0] rs2, input logic [4:0] tag);
    in_valid  = 1'b1;
    in_funct3 = f3;
    in_uw     = uw;
    in_shamt  = sh;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_tag    = tag;
  endtask

  // Single op through the idle two-stage pipe with out_ready=1.
  task automatic run_op(input string name, input logic [2:0] f3, input logic uw, input logic [5:0] sh,
                        input logic [63:0] rs1, input logic [63:0] rs2, input logic [4:0] tag,
                        input logic [63:0] exp_res, input logic exp_ill);
    drive(f3, uw, sh, rs1, rs2, tag);
    #1;
    check({name, "_in_ready"}, in_ready, 1);
    tick;
    in_valid = 1'b0;
    #1;
    check({name, "_valid_early"}, out_valid, 0);
    tick;
    check({name, "_valid"}, out_valid, 1);
    check({name, "_result"}, out_result, exp_res);
    check({name, "_tag"}, out_tag, tag);
    check({name, "_illegal"}, out_illegal, exp_ill);
    tick;
  endtask

  logic [63:0] bp_exp [6];
  int sent, got;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(3'b000, 1'b0, 6'd0, 64'd0, 64'd0, 5'd0);
    in_valid = 1'b0;
    flush32 = 1'b0; in_valid32 = 1'b0; out_ready32 = 1'b1; in_funct3_32 = 3'b000;
    in_uw32 = 1'b0; in_shamt32 = 6'd0; in_rs1_32 = 32'd0; in_rs2_32 = 32'd0; in_tag32 = 5'd0;
    tick;
    tick;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_illegal", out_illegal, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid32", out_valid32, 0);
    rst = 1'b0;
    #1;
    check("rst_release_in_ready", in_ready, 1);
    tick;

    // Latency and basic ops
    run_op("sh3add", 3'b110, 1'b0, 6'd0, 64'h10, 64'h1000, 5'd7, 64'h1080, 1'b0);
    check("idle_after_retire", out_valid, 0);
    run_op("sh2add_uw", 3'b100, 1'b1, 6'd0, 64'hFFFF_FFFF_0000_0001, 64'd1, 5'd1, 64'h5, 1'b0);
    run_op("slli_uw", 3'b001, 1'b1, 6'd40, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 5'd2,
           64'hFFFF_FF00_0000_0000, 1'b0);
    run_op("sh1add_wrap", 3'b010, 1'b0, 6'd0, 64'h8000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF,
           5'd3, 64'h1, 1'b0);
    run_op("illegal_011", 3'b011, 1'b0, 6'd0, 64'h1234, 64'h5678, 5'd4, 64'h0, 1'b1);
    run_op("add_uw", 3'b000, 1'b1, 6'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 5'd5,
           64'h1_0000_0000, 1'b0);
    run_op("add_nouw_illegal", 3'b000, 1'b0, 6'd0, 64'h3, 64'h4, 5'd6, 64'h0, 1'b1);
    run_op("sh2add_full", 3'b100, 1'b0, 6'd0, 64'h4000_0000_0000_0001, 64'd0, 5'd8, 64'h4, 1'b0);

    // Backpressure: 6 back-to-back ops, out_ready low for 5 cycles once full
    for (int k = 0; k < 6; k++) bp_exp[k] = 64'h100 + 64'(2 * k);
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      out_ready = (c >= 7);
      if (sent < 6) drive(3'b010, 1'b0, 6'd0, 64'(sent), 64'h100, 5'(sent));
      else in_valid = 1'b0;
      #1;
      if (c >= 2 && c < 7) begin
        check("bp_in_ready_full", in_ready, 0);
        check("bp_hold_valid", out_valid, 1);
        check("bp_hold_result", out_result, bp_exp[0]);
        check("bp_hold_tag", out_tag, 0);
      end
      if (out_valid && out_ready) begin
        check("bp_order_result", out_result, bp_exp[got]);
        check("bp_order_tag", out_tag, 64'(got));
        got++;
      end
      if (in_valid && in_ready) sent++;
      tick;
    end
    in_valid = 1'b0;
    check("bp_all_retired", 64'(got), 6);
    out_ready = 1'b1;
    tick;

    // Flush with two ops in flight plus a new in_valid
    out_ready = 1'b0;
    drive(3'b010, 1'b0, 6'd0, 64'd1, 64'd1, 5'd11);
    tick;
    drive(3'b010, 1'b0, 6'd0, 64'd2, 64'd2, 5'd12);
    tick;
    flush = 1'b1;
    drive(3'b010, 1'b0, 6'd0, 64'd3, 64'd3, 5'd13);
    #1;
    check("flush_in_ready", in_ready, 0);
    tick;
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_out_valid", out_valid, 0);
    tick;
    check("flush_out_valid_later", out_valid, 0);
    out_ready = 1'b1;
    drive(3'b010, 1'b0, 6'd0, 64'd3, 64'd4, 5'd9);
    #1;
    check("post_flush_in_ready", in_ready, 1);
    tick;
    in_valid = 1'b0;
    #1;
    check("post_flush_valid_early", out_valid, 0);
    tick;
    check("post_flush_valid", out_valid, 1);
    check("post_flush_result", out_result, 64'd10);
    check("post_flush_tag", out_tag, 9);
    tick;

    // Reset in the middle of a stream
    drive(3'b110, 1'b0, 6'd0, 64'd1, 64'd0, 5'd21);
    tick;
    drive(3'b110, 1'b0, 6'd0, 64'd2, 64'd0, 5'd22);
    tick;
    in_valid = 1'b0;
    #1;
    check("midrst_pre_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", in_ready, 0);
    tick;
    rst = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_result", out_result, 0);
    check("midrst_out_tag", out_tag, 0);
    check("midrst_in_ready_after", in_ready, 1);
    tick;
    check("midrst_no_ghost1", out_valid, 0);
    tick;
    check("midrst_no_ghost2", out_valid, 0);

    // RV32 unit: word variants are illegal, base SHnADD wraps at 32 bits
    in_valid32 = 1'b1; in_funct3_32 = 3'b000; in_uw32 = 1'b1; in_rs1_32 = 32'd5;
    in_rs2_32 = 32'd1; in_tag32 = 5'd3;
    #1;
    check("x32_in_ready", in_ready32, 1);
    tick;
    in_valid32 = 1'b0;
    #1;
    check("x32_uw_valid", out_valid32, 1);
    check("x32_uw_illegal", out_illegal32, 1);
    check("x32_uw_result", out_result32, 0);
    check("x32_uw_tag", out_tag32, 3);
    tick;
    in_valid32 = 1'b1; in_funct3_32 = 3'b100; in_uw32 = 1'b0; in_rs1_32 = 32'h8000_0001;
    in_rs2_32 = 32'h10; in_tag32 = 5'd4;
    tick;
    in_valid32 = 1'b0;
    #1;
    check("x32_sh2add_valid", out_valid32, 1);
    check("x32_sh2add_result", out_result32, 64'h14);
    check("x32_sh2add_illegal", out_illegal32, 0);
    tick;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
